mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single byte-wide RAM port between instruction fetch (IF, word reads)
//  and the MEM stage (byte/half/word loads and stores). Serialises each access into
//  per-byte RAM cycles and raises stall requests toward the pipeline stall controller
//  until the access completes. MEM always has priority over IF.
// PARAMETERS
//  ADDR_WIDTH    32  RAM address width; byte addresses wrap modulo 2^ADDR_WIDTH
//  READ_LATENCY  1   cycles from ram_addr driven to ram_din valid; legal 1..2
// PORTS
//  clk          in   1           clock, rising edge
//  rst          in   1           reset, asynchronous, active-high
//  if_req       in   1           IF requests a 4-byte read
//  if_addr      in   ADDR_WIDTH  IF byte address
//  if_data      out  32          fetched word, little-endian, valid while if_done=1
//  if_done      out  1           one-cycle completion pulse for IF
//  mem_req      in   1           MEM requests an access
//  mem_we       in   1           1 = store, 0 = load
//  mem_len      in   2           0 byte, 1 half, 2 word, 3 treated as word
//  mem_addr     in   ADDR_WIDTH  MEM byte address
//  mem_wdata    in   32          store data; byte k = mem_wdata[8k+7:8k]
//  mem_rdata    out  32          load data, zero-extended, valid while mem_done=1
//  mem_done     out  1           one-cycle completion pulse for MEM
//  ram_addr     out  ADDR_WIDTH  RAM byte address
//  ram_we       out  1           RAM write strobe
//  ram_dout     out  8           RAM write byte
//  ram_din      in   8           RAM read byte
//  stallreq_if  out  1           = if_req & ~if_done (combinational)
//  stallreq_mem out  1           = mem_req & ~mem_done (combinational)
// BEHAVIOUR
//  - Reset (async, immediate): state IDLE, byte counter 0, ram_addr/ram_dout/if_data/
//    mem_rdata = 0, ram_we/if_done/mem_done = 0. All are registered outputs.
//  - FSM states: IDLE, IF_RD, MEM_RD, MEM_WR.
//  - IDLE: at edge T0, mem_req=1 -> MEM_RD or MEM_WR; else if_req=1 -> IF_RD.
//    A requester whose done pulse is high in the current cycle is not granted at the
//    next edge (one-cycle turnaround). Address, len, we, wdata are latched at T0;
//    later input changes are ignored until done.
//  - N = 1/2/4 bytes (mem_len 0/1/2-3; IF always 4). Byte k (k=0..N-1) uses address
//    base+k mod 2^ADDR_WIDTH, driven on ram_addr after edge T0+k.
//  - Read: byte k is captured from ram_din at edge T0+k+READ_LATENCY into bits
//    [8k+7:8k]; unused upper bytes 0. After edge T0+N-1+READ_LATENCY: done=1 for one
//    cycle, data valid, state IDLE. ram_addr holds the last address during the
//    capture-only cycles; ram_we=0 throughout.
//  - Write: after edge T0+k, ram_we=1 and ram_dout=wdata byte k. After edge T0+N:
//    ram_we=0, mem_done=1 for one cycle, state IDLE.
//  - if_data/mem_rdata hold their value until the next completion of that requester.
//  - Request withdrawn mid-transaction: the transaction still completes and done pulses.
//  - Reset mid-transaction aborts immediately; partial writes are not undone.
//  - No IF starvation handling: a pending MEM access stalls IF in the pipeline anyway.
// TESTING
//  1. IF read 0x100, RAM[0x100..0x103]=13,05,00,00 -> ram_addr 0x100..0x103,
//     if_done after T0+4, if_data=0x00000513, stallreq_if=0 only in the done cycle.
//  2. if_req and mem_req (load byte 0x2003, RAM=0x9C) in the same cycle -> MEM first:
//     mem_rdata=0x0000009C, mem_done after T0+1; IF is granted after turnaround.
//  3. Store half 0xABCD at 0x3000 -> ram_we high 2 cycles; (0x3000,0xCD), (0x3001,0xAB);
//     mem_done after T0+2.
//  4. IF read at 0xFFFFFFFE -> ram_addr FFFFFFFE, FFFFFFFF, 00000000, 00000001.
//  5. rst asserted between edges during a word store after byte 1 -> ram_we=0 at once,
//     all outputs 0; the next request starts cleanly from IDLE.
//  6. READ_LATENCY=2, word load -> mem_done after T0+5 with the correct word.

Source files
------------

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : IF / MEM request ports, RAM byte port and stall requests of
//               the memory arbiter, bundled for connection to the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [31:0]           if_data;
    logic                  if_done;
    logic                  mem_req;
    logic                  mem_we;
    logic [1:0]            mem_len;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [31:0]           mem_rdata;
    logic                  mem_done;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic                  ram_we;
    logic [7:0]            ram_dout;
    logic [7:0]            ram_din;
    logic                  stallreq_if;
    logic                  stallreq_mem;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
        output if_data, if_done, mem_rdata, mem_done, ram_addr, ram_we, ram_dout,
        output stallreq_if, stallreq_mem
    );

    // Pipeline / RAM side
    modport master (
        output if_req, if_addr, mem_req, mem_we, mem_len, mem_addr, mem_wdata, ram_din,
        input  if_data, if_done, mem_rdata, mem_done, ram_addr, ram_we, ram_dout,
        input  stallreq_if, stallreq_mem
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Serialises IF word reads and MEM byte/half/word accesses onto
//               one byte-wide RAM port; MEM has priority over IF.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  wire logic     clk,
    input  wire logic     rst,
    mem_arbiter_if.slave  bus
);
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_IF_RD  = 2'd1;
    localparam logic [1:0] c_MEM_RD = 2'd2;
    localparam logic [1:0] c_MEM_WR = 2'd3;
    localparam logic [2:0] c_RL     = 3'(READ_LATENCY);

    logic [1:0]            r_state;
    logic [1:0]            w_next;
    logic [2:0]            r_cyc;     // edges elapsed since grant, starts at 1
    logic [2:0]            r_n;       // bytes in the current access
    logic [ADDR_WIDTH-1:0] r_base;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rbuf;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic                  r_ram_we;
    logic [7:0]            r_ram_dout;
    logic [31:0]           r_if_data;
    logic                  r_if_done;
    logic [31:0]           r_mem_rdata;
    logic                  r_mem_done;

    logic [2:0]            w_mem_n;
    logic                  w_grant_mem;
    logic                  w_grant_if;
    logic                  w_rd_last;
    logic                  w_wr_last;
    logic [2:0]            w_cap_idx;
    logic                  w_cap_en;
    logic [ADDR_WIDTH-1:0] w_addr_k;
    logic [31:0]           w_rbuf_nxt;
    logic [7:0]            w_wbyte;

    assign w_mem_n     = (bus.mem_len == 2'd0) ? 3'd1 : (bus.mem_len == 2'd1) ? 3'd2 : 3'd4;
    // A requester whose done pulse is up this cycle sits out the next grant
    assign w_grant_mem = bus.mem_req & ~r_mem_done;
    assign w_grant_if  = bus.if_req & ~r_if_done & ~w_grant_mem;
    assign w_rd_last   = (r_cyc == r_n - 3'd1 + c_RL);
    assign w_wr_last   = (r_cyc == r_n);
    assign w_cap_idx   = r_cyc - c_RL;
    assign w_cap_en    = (r_cyc >= c_RL) && (w_cap_idx < r_n);
    assign w_addr_k    = r_base + ADDR_WIDTH'(r_cyc);

    always_comb begin
        w_rbuf_nxt = r_rbuf;
        if (w_cap_en) begin
            case (w_cap_idx[1:0])
                2'd0:    w_rbuf_nxt[7:0]   = bus.ram_din;
                2'd1:    w_rbuf_nxt[15:8]  = bus.ram_din;
                2'd2:    w_rbuf_nxt[23:16] = bus.ram_din;
                default: w_rbuf_nxt[31:24] = bus.ram_din;
            endcase
        end
    end

    always_comb begin
        case (r_cyc[1:0])
            2'd0:    w_wbyte = r_wdata[7:0];
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            default: w_wbyte = r_wdata[31:24];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_grant_mem)     w_next = bus.mem_we ? c_MEM_WR : c_MEM_RD;
                else if (w_grant_if) w_next = c_IF_RD;
            end
            c_IF_RD, c_MEM_RD: if (w_rd_last) w_next = c_IDLE;
            c_MEM_WR:          if (w_wr_last) w_next = c_IDLE;
            default:           w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cyc       <= 3'd0;
            r_n         <= 3'd0;
            r_base      <= '0;
            r_wdata     <= '0;
            r_rbuf      <= '0;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_dout  <= 8'd0;
            r_if_data   <= '0;
            r_if_done   <= 1'b0;
            r_mem_rdata <= '0;
            r_mem_done  <= 1'b0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            r_cyc      <= r_cyc + 3'd1;
            case (r_state)
                c_IDLE: begin
                    r_cyc    <= 3'd1;
                    r_rbuf   <= '0;
                    r_ram_we <= 1'b0;
                    if (w_grant_mem) begin
                        r_base     <= bus.mem_addr;
                        r_n        <= w_mem_n;
                        r_wdata    <= bus.mem_wdata;
                        r_ram_addr <= bus.mem_addr;
                        r_ram_we   <= bus.mem_we;
                        r_ram_dout <= bus.mem_wdata[7:0];
                    end else if (w_grant_if) begin
                        r_base     <= bus.if_addr;
                        r_n        <= 3'd4;
                        r_ram_addr <= bus.if_addr;
                    end
                end
                c_IF_RD, c_MEM_RD: begin
                    r_rbuf <= w_rbuf_nxt;
                    if (r_cyc < r_n) r_ram_addr <= w_addr_k;
                    if (w_rd_last) begin
                        if (r_state == c_IF_RD) begin
                            r_if_data <= w_rbuf_nxt;
                            r_if_done <= 1'b1;
                        end else begin
                            r_mem_rdata <= w_rbuf_nxt;
                            r_mem_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (w_wr_last) begin
                        r_ram_we   <= 1'b0;
                        r_mem_done <= 1'b1;
                    end else begin
                        r_ram_addr <= w_addr_k;
                        r_ram_we   <= 1'b1;
                        r_ram_dout <= w_wbyte;
                    end
                end
            endcase
        end
    end

    assign bus.ram_addr     = r_ram_addr;
    assign bus.ram_we       = r_ram_we;
    assign bus.ram_dout     = r_ram_dout;
    assign bus.if_data      = r_if_data;
    assign bus.if_done      = r_if_done;
    assign bus.mem_rdata    = r_mem_rdata;
    assign bus.mem_done     = r_mem_done;
    assign bus.stallreq_if  = bus.if_req & ~r_if_done;
    assign bus.stallreq_mem = bus.mem_req & ~r_mem_done;
endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed bench for mem_arbiter at READ_LATENCY 1 and 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0] ram1 [0:65535];
    logic [7:0] ram2 [0:65535];
    logic [7:0] ram2_q = 8'd0;

    mem_arbiter_if #(.ADDR_WIDTH(32)) bus1 ();
    mem_arbiter_if #(.ADDR_WIDTH(32)) bus2 ();

    mem_arbiter #(.ADDR_WIDTH(32), .READ_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    mem_arbiter #(.ADDR_WIDTH(32), .READ_LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    always #5 clk = ~clk;

    // RAM models: combinational read for latency 1, one register stage for latency 2
    assign bus1.ram_din = ram1[bus1.ram_addr[15:0]];
    always @(posedge clk) if (bus1.ram_we) ram1[bus1.ram_addr[15:0]] <= bus1.ram_dout;
    always @(posedge clk) ram2_q <= ram2[bus2.ram_addr[15:0]];
    assign bus2.ram_din = ram2_q;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram1[i] = 8'h00;
            ram2[i] = 8'h00;
        end
        ram1[16'h0100] = 8'h13; ram1[16'h0101] = 8'h05;
        ram1[16'h0102] = 8'h00; ram1[16'h0103] = 8'h00;
        ram1[16'h2003] = 8'h9C;
        ram1[16'h3002] = 8'h55;
        ram1[16'hFFFE] = 8'h11; ram1[16'hFFFF] = 8'h22;
        ram1[16'h0000] = 8'h33; ram1[16'h0001] = 8'h44;
        ram2[16'h5000] = 8'h01; ram2[16'h5001] = 8'h02;
        ram2[16'h5002] = 8'h03; ram2[16'h5003] = 8'h80;

        bus1.if_req = 0; bus1.if_addr = 0; bus1.mem_req = 0; bus1.mem_we = 0;
        bus1.mem_len = 0; bus1.mem_addr = 0; bus1.mem_wdata = 0;
        bus2.if_req = 0; bus2.if_addr = 0; bus2.mem_req = 0; bus2.mem_we = 0;
        bus2.mem_len = 0; bus2.mem_addr = 0; bus2.mem_wdata = 0;

        // Reset state
        repeat (2) step();
        check("rst_ram_addr", 64'(bus1.ram_addr), 64'h0);
        check("rst_outs", {bus1.ram_we, bus1.if_done, bus1.mem_done, bus1.ram_dout},
              {1'b0, 1'b0, 1'b0, 8'h00});
        check("rst_data", {bus1.if_data, bus1.mem_rdata}, 64'h0);
        rst = 0;
        step();

        // IF word read at 0x100
        bus1.if_req = 1; bus1.if_addr = 32'h100;
        for (int k = 0; k < 4; k++) begin
            step();
            check("if_addr_seq", 64'(bus1.ram_addr), 64'(32'h100 + k));
            check("if_stall", {bus1.stallreq_if, bus1.if_done, bus1.ram_we}, 3'b100);
        end
        step();
        check("if_done", {bus1.if_done, bus1.stallreq_if}, 2'b10);
        check("if_data", 64'(bus1.if_data), 64'h00000513);
        check("if_addr_hold", 64'(bus1.ram_addr), 64'h103);
        bus1.if_req = 0;
        step();
        check("if_done_pulse", 64'(bus1.if_done), 64'h0);

        // Simultaneous IF and MEM byte load: MEM first, IF after turnaround
        bus1.if_req = 1; bus1.if_addr = 32'h100;
        bus1.mem_req = 1; bus1.mem_we = 0; bus1.mem_len = 2'd0; bus1.mem_addr = 32'h2003;
        step();
        check("prio_addr", 64'(bus1.ram_addr), 64'h2003);
        check("prio_stall", {bus1.stallreq_mem, bus1.stallreq_if}, 2'b11);
        step();
        check("lb_done", {bus1.mem_done, bus1.stallreq_mem, bus1.if_done}, 3'b100);
        check("lb_data", 64'(bus1.mem_rdata), 64'h0000009C);
        step();
        check("turn_if_grant", 64'(bus1.ram_addr), 64'h100);
        check("turn_mem_done", 64'(bus1.mem_done), 64'h0);
        bus1.mem_req = 0;
        repeat (4) step();
        check("turn_if_done", {bus1.if_done, bus1.mem_done}, 2'b10);
        check("turn_if_data", 64'(bus1.if_data), 64'h00000513);
        check("lb_data_hold", 64'(bus1.mem_rdata), 64'h0000009C);
        bus1.if_req = 0;
        step();

        // Half store 0xABCD at 0x3000
        bus1.mem_req = 1; bus1.mem_we = 1; bus1.mem_len = 2'd1;
        bus1.mem_addr = 32'h3000; bus1.mem_wdata = 32'h1234ABCD;
        step();
        bus1.mem_wdata = 32'hFFFFFFFF;
        check("sh_b0", {bus1.ram_we, bus1.ram_addr, bus1.ram_dout}, {1'b1, 32'h3000, 8'hCD});
        step();
        check("sh_b1", {bus1.ram_we, bus1.ram_addr, bus1.ram_dout}, {1'b1, 32'h3001, 8'hAB});
        check("sh_nodone", 64'(bus1.mem_done), 64'h0);
        step();
        check("sh_done", {bus1.ram_we, bus1.mem_done}, 2'b01);
        bus1.mem_req = 0; bus1.mem_we = 0;
        check("sh_ram", {ram1[16'h3000], ram1[16'h3001], ram1[16'h3002]}, 24'hCDAB55);
        step();

        // IF read wrapping past the top of the address space
        bus1.if_req = 1; bus1.if_addr = 32'hFFFFFFFE;
        step(); check("wrap_a0", 64'(bus1.ram_addr), 64'hFFFFFFFE);
        step(); check("wrap_a1", 64'(bus1.ram_addr), 64'hFFFFFFFF);
        step(); check("wrap_a2", 64'(bus1.ram_addr), 64'h00000000);
        step(); check("wrap_a3", 64'(bus1.ram_addr), 64'h00000001);
        step();
        check("wrap_data", {bus1.if_done, bus1.if_data}, {1'b1, 32'h44332211});
        bus1.if_req = 0;
        step();

        // Reset in the middle of a word store, after byte 1 has been driven
        bus1.mem_req = 1; bus1.mem_we = 1; bus1.mem_len = 2'd2;
        bus1.mem_addr = 32'h4000; bus1.mem_wdata = 32'hDEADBEEF;
        step();
        step();
        check("ws_b1", {bus1.ram_we, bus1.ram_addr, bus1.ram_dout}, {1'b1, 32'h4001, 8'hBE});
        #2;
        rst = 1; bus1.mem_req = 0; bus1.mem_we = 0;
        #1;
        check("ws_rst_we", {bus1.ram_we, bus1.ram_addr, bus1.ram_dout}, {1'b0, 32'h0, 8'h00});
        check("ws_rst_data", {bus1.if_data, bus1.mem_rdata}, 64'h0);
        #1;
        rst = 0;
        step();
        check("ws_partial", {ram1[16'h4000], ram1[16'h4001]}, 16'hEF00);
        bus1.mem_req = 1; bus1.mem_we = 0; bus1.mem_len = 2'd2; bus1.mem_addr = 32'h100;
        step();
        check("post_rst_start", {bus1.ram_we, bus1.ram_addr}, {1'b0, 32'h100});
        repeat (3) step();
        check("post_rst_nodone", 64'(bus1.mem_done), 64'h0);
        step();
        check("post_rst_lw", {bus1.mem_done, bus1.mem_rdata}, {1'b1, 32'h00000513});
        bus1.mem_req = 0;
        step();

        // Word load with READ_LATENCY = 2
        bus2.mem_req = 1; bus2.mem_we = 0; bus2.mem_len = 2'd3; bus2.mem_addr = 32'h5000;
        step();
        bus2.mem_addr = 32'h0;
        repeat (3) step();
        check("rl2_a3", 64'(bus2.ram_addr), 64'h5003);
        step();
        check("rl2_hold", {bus2.ram_addr, bus2.mem_done}, {32'h5003, 1'b0});
        step();
        check("rl2_lw", {bus2.mem_done, bus2.mem_rdata}, {1'b1, 32'h80030201});
        bus2.mem_req = 0;
        step();
        check("rl2_pulse", 64'(bus2.mem_done), 64'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
